// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the fetch unit and its sub-modules.
//   JUMP_*           : encodings of the decoder's 2-bit jump field
//   fetch_state_t    : fetch sequencer states
//   RESET_PC_DEFAULT : default reset program counter
package cpu_pkg;

    localparam logic [1:0] JUMP_SEQ = 2'b00;  // sequential or conditional branch
    localparam logic [1:0] JUMP_REG = 2'b01;  // JR
    localparam logic [1:0] JUMP_IMM = 2'b10;  // J / JAL

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH,
        EXEC
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read port.
//   req   : read request (fetch side drives)
//   addr  : read address (fetch side drives)
//   ack   : read data valid this cycle (memory drives)
//   rdata : instruction word (memory drives)
interface fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational next-PC selection.
//   pc_plus4  in  32 : address of the current instruction plus 4
//   instr     in  32 : current instruction word (jump index / branch offset)
//   jump      in   2 : decoder jump field
//   branch    in   1 : decoder branch flag
//   zero      in   1 : ALU zero flag
//   jr_target in  32 : rs register value for JR
//   next_pc   out 32 : selected next program counter
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [1:0]  jump,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [31:0] branch_off;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_aligned;

    // Sign-extended word offset, scaled to bytes.
    assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_off;
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    // Misaligned register targets are forced onto a word boundary.
    assign jr_aligned    = {jr_target[31:2], 2'b00};

    // Opcode bits and JR low bits play no part in target selection.
    logic unused_bits;
    assign unused_bits = ^{instr[31:26], jr_target[1:0]};

    always_comb begin
        next_pc = pc_plus4;
        unique case (jump)
            JUMP_IMM: next_pc = jump_target;
            JUMP_REG: next_pc = jr_aligned;
            JUMP_SEQ: if (branch && zero) next_pc = branch_target;
            default:  next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: two-state instruction fetch and PC sequencer.
//   clk         in   1 : clock, rising edge
//   reset       in   1 : synchronous active-high reset
//   imem        if     : instruction-memory port (master side)
//   instr       out 32 : registered instruction, stable while in EXEC
//   instr_valid out  1 : high while in EXEC
//   commit      out  1 : instr_valid & ~stall; gates architectural writes
//   pc          out 32 : address of the current instruction
//   pc_plus4    out 32 : pc + 4, JAL link value
//   branch      in   1 : decoder branch flag
//   zero        in   1 : ALU zero flag
//   jump        in   2 : decoder jump field
//   jr_target   in  32 : rs register value
//   stall       in   1 : downstream busy, holds EXEC
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       imem,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic               commit,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               branch,
    input  logic               zero,
    input  logic [1:0]         jump,
    input  logic [31:0]        jr_target,
    input  logic               stall
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  next_pc;
    logic         instr_en;
    logic         pc_en;
    logic         req_dec;
    logic         valid_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_en) instr_q <= imem.rdata;
            if (pc_en)    pc_q    <= next_pc;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_en  = 1'b0;
        pc_en     = 1'b0;
        req_dec   = 1'b0;
        valid_dec = 1'b0;
        unique case (state_q)
            FETCH: begin
                req_dec = 1'b1;
                if (imem.ack) begin
                    instr_en = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                valid_dec = 1'b1;
                if (!stall) begin
                    pc_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset masks the decoded outputs in the same cycle it is asserted.
    assign imem.req    = req_dec & ~reset;
    assign imem.addr   = pc_q;
    assign instr_valid = valid_dec & ~reset;
    assign commit      = instr_valid & ~stall;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;

    next_pc_sel u_next_pc_sel (
        .pc_plus4  (pc_plus4),
        .instr     (instr_q),
        .jump      (jump),
        .branch    (branch),
        .zero      (zero),
        .jr_target (jr_target),
        .next_pc   (next_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// behavioural next-PC model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        commit;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch;
    logic        zero;
    logic [1:0]  jump;
    logic [31:0] jr_target;
    logic        stall;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;

    fetch_unit_if imem ();

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem),
        .instr       (instr),
        .instr_valid (instr_valid),
        .commit      (commit),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .jr_target   (jr_target),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference next-PC computed directly from the instruction-set rules.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic br, input logic zr,
                                             input logic [1:0] jmp, input logic [31:0] jrt);
        logic [31:0]        seq;
        logic signed [15:0] imm;
        int                 off;
        seq = cur + 32'd4;
        imm = word[15:0];
        off = int'(imm) * 4;
        case (jmp)
            2'b10:   return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
            2'b01:   return jrt & 32'hFFFF_FFFC;
            2'b00:   return (br && zr) ? seq + 32'(off) : seq;
            default: return seq;
        endcase
    endfunction

    task automatic scramble_ctrl();
        branch    = 1'($urandom_range(0, 1));
        zero      = 1'($urandom_range(0, 1));
        jump      = 2'($urandom_range(0, 3));
        jr_target = $urandom;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            #1;
            chk("rst_req", 32'(imem.req), 32'd0);
            chk("rst_valid", 32'(instr_valid), 32'd0);
            chk("rst_commit", 32'(commit), 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        exp_pc = 32'h0;
        chk("post_rst_pc", pc, 32'h0);
        chk("post_rst_instr", instr, 32'h0);
        chk("post_rst_valid", 32'(instr_valid), 32'd0);
        chk("post_rst_req", 32'(imem.req), 32'd1);
        chk("post_rst_addr", imem.addr, 32'h0);
    endtask

    task automatic fetch_phase(input logic [31:0] word, input int waits);
        stall = 1'b0;
        for (int i = 0; i < waits; i++) begin
            imem.ack   = 1'b0;
            imem.rdata = $urandom;
            scramble_ctrl();
            #1;
            chk("wait_req", 32'(imem.req), 32'd1);
            chk("wait_addr", imem.addr, exp_pc);
            chk("wait_valid", 32'(instr_valid), 32'd0);
            chk("wait_commit", 32'(commit), 32'd0);
            @(posedge clk); #1;
        end
        imem.ack   = 1'b1;
        imem.rdata = word;
        #1;
        chk("ack_req", 32'(imem.req), 32'd1);
        chk("ack_addr", imem.addr, exp_pc);
        @(posedge clk); #1;
        // Ack and data are don't-care outside FETCH.
        imem.ack   = 1'($urandom_range(0, 1));
        imem.rdata = $urandom;
    endtask

    task automatic stall_phase(input logic [31:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            stall = 1'b1;
            scramble_ctrl();
            #1;
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_commit", 32'(commit), 32'd0);
            chk("stall_instr", instr, word);
            chk("stall_pc", pc, exp_pc);
            @(posedge clk); #1;
        end
    endtask

    task automatic commit_phase(input logic [31:0] word, input logic br, input logic zr,
                                input logic [1:0] jmp, input logic [31:0] jrt);
        logic [31:0] nxt;
        stall     = 1'b0;
        branch    = br;
        zero      = zr;
        jump      = jmp;
        jr_target = jrt;
        #1;
        chk("exec_valid", 32'(instr_valid), 32'd1);
        chk("exec_commit", 32'(commit), 32'd1);
        chk("exec_instr", instr, word);
        chk("exec_pc", pc, exp_pc);
        chk("exec_pc_plus4", pc_plus4, exp_pc + 32'd4);
        nxt = ref_next(exp_pc, word, br, zr, jmp, jrt);
        @(posedge clk); #1;
        exp_pc = nxt;
        chk("next_pc", pc, exp_pc);
        chk("next_valid", 32'(instr_valid), 32'd0);
        chk("next_commit", 32'(commit), 32'd0);
        chk("next_addr", imem.addr, exp_pc);
    endtask

    task automatic run_instr(input logic [31:0] word, input int waits, input int stalls,
                             input logic br, input logic zr, input logic [1:0] jmp,
                             input logic [31:0] jrt);
        fetch_phase(word, waits);
        stall_phase(word, stalls);
        commit_phase(word, br, zr, jmp, jrt);
    endtask

    // Move the PC to an arbitrary address with a zero-wait JR.
    task automatic goto(input logic [31:0] target);
        run_instr(32'h0000_0008, 0, 0, 1'b0, 1'b0, 2'b01, target);
    endtask

    initial begin
        reset      = 1'b1;
        imem.ack   = 1'b0;
        imem.rdata = '0;
        stall      = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        jump       = 2'b00;
        jr_target  = '0;
        exp_pc     = '0;
        @(posedge clk); #1;

        // Reset, then four zero-wait NOPs.
        do_reset(3);
        for (int i = 0; i < 4; i++) begin
            chk("nop_addr", imem.addr, 32'(i * 4));
            run_instr(32'h0, 0, 0, 1'b0, 1'b0, 2'b00, 32'h0);
        end
        chk("nop_end", pc, 32'h10);

        // Wait states and stall.
        run_instr(32'h2108_0001, 3, 2, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("wait_stall_pc", pc, 32'h14);

        // Branches.
        goto(32'h100);
        run_instr(32'h1000_FFFF, 0, 0, 1'b1, 1'b1, 2'b00, 32'h0);
        chk("beq_self", pc, 32'h100);
        run_instr(32'h1000_FFFF, 0, 0, 1'b1, 1'b0, 2'b00, 32'h0);
        chk("beq_not_taken", pc, 32'h104);
        goto(32'h100);
        run_instr(32'h1000_0004, 0, 0, 1'b1, 1'b1, 2'b00, 32'h0);
        chk("beq_fwd", pc, 32'h114);

        // Jumps.
        goto(32'h3000_0010);
        fetch_phase(32'h0C00_0040, 0);
        chk("jal_link", pc_plus4, 32'h3000_0014);
        commit_phase(32'h0C00_0040, 1'b0, 1'b0, 2'b10, 32'h0);
        chk("j_target", pc, 32'h3000_0100);
        run_instr(32'h0000_0008, 0, 0, 1'b0, 1'b0, 2'b01, 32'h0000_2003);
        chk("jr_align", pc, 32'h0000_2000);
        run_instr(32'h0800_0040, 0, 0, 1'b0, 1'b0, 2'b11, 32'h5555_5555);
        chk("jump_rsvd", pc, 32'h0000_2004);
        run_instr(32'h0800_0040, 0, 0, 1'b1, 1'b1, 2'b10, 32'h0);
        chk("jump_over_branch", pc, 32'h0000_0100);

        // Wrap-around.
        goto(32'hFFFF_FFFC);
        run_instr(32'h0, 0, 0, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("wrap", pc, 32'h0);

        // Reset mid-FETCH with an ack arriving alongside reset; a late ack is
        // then taken as the word at RESET_PC.
        goto(32'h200);
        imem.ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        imem.ack   = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        do_reset(1);
        run_instr(32'h1234_5678, 0, 0, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("late_ack_pc", pc, 32'h4);

        // Reset during a stalled EXEC.
        goto(32'h300);
        fetch_phase(32'hCAFE_0001, 1);
        stall_phase(32'hCAFE_0001, 1);
        stall = 1'b1;
        do_reset(2);
        stall = 1'b0;
        run_instr(32'h0, 0, 0, 1'b0, 1'b0, 2'b00, 32'h0);
        chk("restart_pc", pc, 32'h4);

        // Randomized instruction stream.
        for (int i = 0; i < 40; i++) begin
            run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Multi-cycle instruction fetch and program-counter sequencer for the single-cycle MIPS core. It issues instruction-memory reads, holds the fetched word for the decode/execute datapath, and computes the next PC from the main decoder's `branch` and `jump` outputs plus the ALU `zero` flag. It sits directly upstream of the main decoder: it produces `instr`, whose opcode and funct fields the decoder consumes, and it consumes the decoder's control-flow outputs. It also provides `pc_plus4` for the JAL link write.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; bits [1:0] must be 0.

**Ports**
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: instruction read request.
- `imem_addr` out 32: read address, always equal to `pc`.
- `imem_ack` in 1: read data valid this cycle.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: registered instruction, stable while in EXEC.
- `instr_valid` out 1: high while in EXEC.
- `commit` out 1: `instr_valid & ~stall`. Register-file and data-memory writes must be gated by this signal.
- `pc` out 32: address of the current instruction.
- `pc_plus4` out 32: `pc + 4`, used as the JAL link value.
- `branch` in 1: from the decoder.
- `zero` in 1: from the ALU.
- `jump` in 2: from the decoder. `00` = sequential/branch, `01` = JR, `10` = J/JAL, `11` = reserved.
- `jr_target` in 32: rs register value.
- `stall` in 1: downstream busy; holds EXEC.

## Operation

**States**
- FETCH:
  - `imem_req` = 1, `imem_addr` = `pc`.
  - On `imem_ack`: `instr` <= `imem_rdata`, go to EXEC.
  - Otherwise stay in FETCH; request and address are held.
- EXEC:
  - `instr_valid` = 1.
  - If `stall`: stay in EXEC; `pc` and `instr` are unchanged.
  - Else: `pc` <= `next_pc`, go to FETCH.

**`next_pc` selection** (all arithmetic is mod 2^32; wrap-around is silent)
- `jump == 10`: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
- `jump == 01`: `{jr_target[31:2], 2'b00}`. Misaligned low bits are dropped.
- `jump == 00` with `branch & zero`: `pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})`.
- Otherwise, including `jump == 11`: `pc_plus4`.

**Rules**
- Jump takes priority over branch.
- `imem_ack` is ignored outside FETCH.
- `branch`, `zero`, `jump` and `jr_target` are sampled only on the EXEC cycle where `~stall`.

**Reset** (reset overrides everything; it can be asserted mid-FETCH or mid-EXEC)
- State <= FETCH, `pc` <= `RESET_PC`, `instr` <= 0.
- While `reset` is high: `imem_req` = 0, `instr_valid` = 0, `commit` = 0.
- An outstanding fetch is abandoned. A late `imem_ack` in the cycle after reset deasserts is accepted as data for `RESET_PC`; the memory must not ack a stale request.

## Timing

- The first `imem_req` is asserted in the first cycle after `reset` deasserts.
- Zero-wait memory (ack in the same cycle as req): 2 cycles per instruction (FETCH, EXEC).
- Each memory wait cycle adds 1 cycle; each `stall` cycle adds 1 cycle.
- `instr`, `pc` and `pc_plus4` are registered or derived from registers. `imem_req`, `instr_valid` and `commit` are decoded from the state register.
- `next_pc` is combinational; `pc` updates at the clock edge ending the committing EXEC cycle.
- `commit` is high for exactly one cycle per instruction.

## Structure

**Shared package (`cpu_pkg`)**
- Jump encodings `JUMP_SEQ`, `JUMP_REG`, `JUMP_IMM`.
- State enum `fetch_state_t` {FETCH, EXEC}.
- `RESET_PC` default.

**Sub-module**
- `next_pc_sel`: purely combinational target mux and adders (`pc_plus4`, `instr`, `jump`, `branch`, `zero`, `jr_target` -> `next_pc`).
- `fetch_unit` holds the state machine and the `pc`/`instr` registers.

## Test plan

1. **Reset and sequential fetch.** Reset with `RESET_PC = 0`, zero-wait ack, four NOPs.
   - `imem_addr` sequence 0, 4, 8, C.
   - `commit` pulses every 2nd cycle.
   - No `imem_req` during reset.
2. **Wait states and stall.**
   - Ack delayed 3 cycles: `instr_valid` stays 0 and `imem_addr` is held.
   - `stall` for 2 cycles in EXEC: `pc` is held, `commit` = 0 for those cycles, then one `commit` pulse.
3. **Branches.** At `pc = 0x100`: BEQ with imm `0xFFFF`, `branch = 1`, `zero = 1` -> next `pc = 0x100`.
   - Same instruction with `zero = 0` -> `0x104`.
   - imm `0x0004` taken -> `0x114`.
4. **Jumps.**
   - At `pc = 0x3000_0010`, J with target field `0x0000040` -> `0x3000_0100`; `pc_plus4` = `0x3000_0014` during JAL.
   - JR with `jr_target = 0x0000_2003` -> `0x0000_2000`.
   - `jump = 11` -> `pc + 4`.
   - `jump = 10` with `branch = 1`, `zero = 1` -> jump target wins.
5. **Wrap-around.** `pc = 0xFFFF_FFFC`, sequential -> `0x0000_0000`.
6. **Reset mid-operation.**
   - `reset` asserted mid-FETCH with ack pending, and separately during a stalled EXEC.
   - Next cycle: `pc = RESET_PC`, `instr = 0`, `instr_valid = 0`; fetch restarts at `RESET_PC`.
